axis_i2c_arbiter: RTL and testbench
===================================

AXIS_I2C_ARBITER -- requirements
Module: axis_i2c_arbiter

Interface
REQ-001 Parameter N_PORTS, default 2, number of AXI-Stream requesters sharing the I2C master command stream (legal 2..4).
REQ-002 Parameter BURST_LEN, default 3, beats per grant, one I2C transaction (legal 1..255).
REQ-003 Parameter TIMEOUT, default 255, idle cycles with granted tvalid low before forced release; 0 disables the timeout.
REQ-004 Data width SHALL be AXIS_DATA_WIDTH from axis_i2c_pkg (W below).
REQ-005 clk_i  input  1  sole clock, all logic rising-edge.
REQ-006 arstn_i  input  1  reset, asynchronous assert, active-low.
REQ-007 s_tdata_i  input  N_PORTS*W  requester data, port k at bits [k*W +: W].
REQ-008 s_tvalid_i  input  N_PORTS  requester valid.
REQ-009 s_tready_o  output  N_PORTS  requester ready.
REQ-010 m_tdata_o  output  W  data to I2C master.
REQ-011 m_tvalid_o  output  1  valid to I2C master.
REQ-012 m_tready_i  input  1  ready from I2C master.
REQ-013 grant_o  output  N_PORTS  one-hot current grant, all-zero when idle.
REQ-014 busy_o  output  1  high in BUSY state.
REQ-015 timeout_o  output  1  one-cycle pulse on forced release.

Function
REQ-016 States: IDLE, BUSY; registers: state, grant index, last_grant index, beat counter (8 bit), idle counter (8 bit).
REQ-017 IDLE: s_tready_o=0, m_tvalid_o=0, m_tdata_o=0, grant_o=0, busy_o=0.
REQ-018 IDLE with any s_tvalid_i high: grant SHALL go to first requesting port searching round-robin from last_grant+1 (mod N_PORTS), entering BUSY next cycle; beat and idle counters cleared.
REQ-019 Arbitration latency: exactly one cycle from first tvalid in IDLE to m_tvalid_o high.
REQ-020 BUSY: m_tdata_o/m_tvalid_o combinationally pass the granted port; s_tready_o[grant]=m_tready_i; all other s_tready_o bits 0.
REQ-021 Beat = m_tvalid_o & m_tready_i; each beat increments beat counter.
REQ-022 Beat while beat counter = BURST_LEN-1: return to IDLE next cycle, last_grant<=grant; no re-grant in that same cycle.
REQ-023 Idle counter increments each BUSY cycle with granted tvalid low, clears on granted tvalid high.
REQ-024 TIMEOUT>0 and idle counter reaching TIMEOUT-1 with tvalid still low: go IDLE, last_grant<=grant, timeout_o pulses one cycle.
REQ-025 Timeout SHALL never fire while granted tvalid is high; a pending beat is never dropped; last beat and timeout cannot coincide.
REQ-026 Non-granted requesters SHALL be held (tready 0) until granted; grant does not change mid-burst.
REQ-027 A requester raising tvalid and data is held by its own AXIS rules; arbiter imposes no data buffering.

Reset
REQ-028 arstn_i low: state IDLE, last_grant=N_PORTS-1 (port 0 first priority), counters 0, all outputs 0, immediately and asynchronously.
REQ-029 Reset mid-burst abandons the burst; first post-reset grant follows REQ-018 with last_grant=N_PORTS-1.

Verification
REQ-030 Ports 0 and 1 both valid from reset release, m_tready_i=1, BURST_LEN=3 -> port 0 granted, beats 0..2 from port 0, one IDLE cycle, then port 1 three beats.
REQ-031 Port 1 alone valid, m_tready_i toggling 1/0 -> exactly 3 beats forwarded in order, s_tready_o[1] mirrors m_tready_i, s_tready_o[0]=0 throughout.
REQ-032 Port 0 granted, sends 1 beat then drops tvalid, TIMEOUT=4 -> after 4 low cycles timeout_o pulses once, state IDLE, next grant port 1 if requesting.
REQ-033 Port 0 granted, tvalid high with m_tready_i=0 for 300 cycles -> no timeout, grant held, beat completes when ready rises.
REQ-034 arstn_i pulsed low after 2nd beat of port 1 burst -> outputs 0 immediately; after release with both valid, port 0 granted first.
REQ-035 Three ports continuously valid, N_PORTS=3 -> grant sequence 0,1,2,0 with each burst exactly BURST_LEN beats.

Source files
------------

// File: rtl/axis_i2c_arbiter.sv
// Round-robin arbiter that lets several AXI-Stream requesters share one I2C master
// command stream, granting one fixed-length burst (one I2C transaction) at a time.
package axis_i2c_pkg;
    parameter int AXIS_DATA_WIDTH = 8;
endpackage

module axis_i2c_arbiter
    import axis_i2c_pkg::*;
#(
    parameter int N_PORTS   = 2,
    parameter int BURST_LEN = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic                               clk_i,
    input  logic                               arstn_i,
    input  logic [N_PORTS*AXIS_DATA_WIDTH-1:0] s_tdata_i,
    input  logic [N_PORTS-1:0]                 s_tvalid_i,
    output logic [N_PORTS-1:0]                 s_tready_o,
    output logic [AXIS_DATA_WIDTH-1:0]         m_tdata_o,
    output logic                               m_tvalid_o,
    input  logic                               m_tready_i,
    output logic [N_PORTS-1:0]                 grant_o,
    output logic                               busy_o,
    output logic                               timeout_o
);
    localparam int              W         = AXIS_DATA_WIDTH;
    localparam int              IW        = $clog2(N_PORTS);
    localparam bit              TO_EN     = (TIMEOUT > 0);
    localparam logic [7:0]      BEAT_LAST = 8'(BURST_LEN - 1);
    localparam logic [7:0]      IDLE_LAST = TO_EN ? 8'(TIMEOUT - 1) : 8'd0;
    localparam logic [IW-1:0]   PORT_LAST = IW'(N_PORTS - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [IW-1:0] grant_idx;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] cand;
    logic          pick_vld;
    logic [7:0]    beat_cnt;
    logic [7:0]    idle_cnt;
    logic          gnt_valid;
    logic          beat;

    // Search starts just past the previous winner so every port gets its turn.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int unsigned i = 1; i <= N_PORTS; i++) begin
            cand = IW'((32'(last_grant) + i) % 32'(N_PORTS));
            if (!pick_vld && s_tvalid_i[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        s_tready_o = '0;
        grant_o    = '0;
        m_tdata_o  = '0;
        gnt_valid  = 1'b0;
        if (state == BUSY) begin
            s_tready_o[grant_idx] = m_tready_i;
            grant_o[grant_idx]    = 1'b1;
            m_tdata_o             = s_tdata_i[32'(grant_idx)*W +: W];
            gnt_valid             = s_tvalid_i[grant_idx];
        end
    end

    assign m_tvalid_o = gnt_valid;
    assign beat       = gnt_valid & m_tready_i;
    assign busy_o     = (state == BUSY);

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state      <= IDLE;
            grant_idx  <= '0;
            last_grant <= PORT_LAST;
            beat_cnt   <= '0;
            idle_cnt   <= '0;
            timeout_o  <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state     <= BUSY;
                        grant_idx <= pick_idx;
                        beat_cnt  <= '0;
                        idle_cnt  <= '0;
                    end
                end
                BUSY: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (beat_cnt == BEAT_LAST) begin
                            state      <= IDLE;
                            last_grant <= grant_idx;
                        end
                    end
                    // A beat needs tvalid high, so it can never meet the timeout branch.
                    if (gnt_valid) begin
                        idle_cnt <= '0;
                    end else if (TO_EN && idle_cnt == IDLE_LAST) begin
                        state      <= IDLE;
                        last_grant <= grant_idx;
                        timeout_o  <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_i2c_arbiter.sv
// Scoreboard bench for axis_i2c_arbiter: queued requester sources, expected beats
// pushed at stimulus time, a negedge monitor pops and compares every forwarded beat.
module tb_axis_i2c_arbiter;
    import axis_i2c_pkg::*;

    localparam int W  = AXIS_DATA_WIDTH;
    localparam int NP = 3;

    logic            clk_i = 1'b0;
    logic            arstn_i;
    logic [NP*W-1:0] s_tdata_i;
    logic [NP-1:0]   s_tvalid_i;
    logic [NP-1:0]   s_tready_o;
    logic [W-1:0]    m_tdata_o;
    logic            m_tvalid_o;
    logic            m_tready_i;
    logic [NP-1:0]   grant_o;
    logic            busy_o;
    logic            timeout_o;

    axis_i2c_arbiter #(
        .N_PORTS  (NP),
        .BURST_LEN(3),
        .TIMEOUT  (4)
    ) dut (
        .clk_i     (clk_i),
        .arstn_i   (arstn_i),
        .s_tdata_i (s_tdata_i),
        .s_tvalid_i(s_tvalid_i),
        .s_tready_o(s_tready_o),
        .m_tdata_o (m_tdata_o),
        .m_tvalid_o(m_tvalid_o),
        .m_tready_i(m_tready_i),
        .grant_o   (grant_o),
        .busy_o    (busy_o),
        .timeout_o (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int           port;
        logic [W-1:0] data;
    } exp_t;

    exp_t         sb_q[$];
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [W-1:0] q2[$];
    int           total = 0;
    int           bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic src_push(input int port, input logic [W-1:0] d);
        case (port)
            0: q0.push_back(d);
            1: q1.push_back(d);
            default: q2.push_back(d);
        endcase
    endtask

    task automatic exp_push(input int port, input logic [W-1:0] d);
        exp_t e;
        e.port = port;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic burst(input int port, input logic [W-1:0] base, input bit to_src, input bit to_exp);
        for (int i = 0; i < 3; i++) begin
            if (to_src) src_push(port, base + W'(i));
            if (to_exp) exp_push(port, base + W'(i));
        end
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 400; n++) begin
            @(negedge clk_i);
            #1;
            if (sb_q.size() == 0 && !busy_o) break;
        end
        check(name, {31'd0, (sb_q.size() == 0 && !busy_o)}, 32'd1);
    endtask

    // Requester sources: present queue heads, pop on a handshake seen before the edge.
    initial begin
        logic [NP-1:0] fire;
        s_tvalid_i = '0;
        s_tdata_i  = '0;
        forever begin
            @(negedge clk_i);
            fire = s_tvalid_i & s_tready_o;
            @(posedge clk_i);
            #1;
            if (fire[0] && q0.size() != 0) void'(q0.pop_front());
            if (fire[1] && q1.size() != 0) void'(q1.pop_front());
            if (fire[2] && q2.size() != 0) void'(q2.pop_front());
            s_tvalid_i = {q2.size() != 0, q1.size() != 0, q0.size() != 0};
            s_tdata_i  = {(q2.size() != 0) ? q2[0] : W'(0),
                          (q1.size() != 0) ? q1[0] : W'(0),
                          (q0.size() != 0) ? q0[0] : W'(0)};
        end
    end

    // Monitor: every forwarded beat must match the next expected port/data.
    initial begin
        exp_t          e;
        logic [NP-1:0] eg;
        forever begin
            @(negedge clk_i);
            if (arstn_i && m_tvalid_o && m_tready_i) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL beat_unexpected actual data=%0h grant=%b required none", m_tdata_o, grant_o);
                end else begin
                    e  = sb_q.pop_front();
                    eg = NP'(1) << e.port;
                    if (m_tdata_o !== e.data || grant_o !== eg) begin
                        bad++;
                        $display("FAIL beat actual data=%0h grant=%b required data=%0h grant=%b",
                                 m_tdata_o, grant_o, e.data, eg);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] bp;
        logic [6:0] bp3;
        logic [6:0] tp3;
        int         hold_bad;

        arstn_i    = 1'b0;
        m_tready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("reset_out", {15'd0, m_tvalid_o, busy_o, timeout_o, grant_o, s_tready_o, m_tdata_o}, 32'd0);

        // Ports 0 and 1 valid from reset release: port 0 burst, one idle cycle, port 1 burst.
        burst(0, 8'h00, 1'b1, 1'b1);
        burst(1, 8'h10, 1'b1, 1'b1);
        m_tready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        arstn_i = 1'b1;
        bp = 8'b0111_0111;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i);
            #2;
            check($sformatf("t1_busy%0d", i), {31'd0, busy_o}, {31'd0, bp[i]});
            check($sformatf("t1_grant%0d", i), {29'd0, grant_o},
                  {29'd0, bp[i] ? ((i < 4) ? 3'b001 : 3'b010) : 3'b000});
        end
        drain("t1_drain");

        // Port 1 alone with a toggling downstream ready.
        burst(1, 8'h20, 1'b1, 1'b1);
        for (int n = 0; n < 80; n++) begin
            @(posedge clk_i);
            #1;
            m_tready_i = ~m_tready_i;
            @(negedge clk_i);
            if (busy_o) check("t2_tready", {29'd0, s_tready_o}, {29'd0, 1'b0, m_tready_i, 1'b0});
            #1;
            if (sb_q.size() == 0 && !busy_o) break;
        end
        drain("t2_drain");
        m_tready_i = 1'b1;

        // Port 0 sends one beat then goes quiet: timeout after four idle cycles, then port 1.
        src_push(0, 8'h30);
        exp_push(0, 8'h30);
        burst(1, 8'h40, 1'b1, 1'b1);
        @(posedge clk_i);
        bp3 = 7'b101_1111;
        tp3 = 7'b010_0000;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk_i);
            #2;
            check($sformatf("t3_busy%0d", i), {31'd0, busy_o}, {31'd0, bp3[i]});
            check($sformatf("t3_timeout%0d", i), {31'd0, timeout_o}, {31'd0, tp3[i]});
        end
        check("t3_next_grant", {29'd0, grant_o}, 32'd2);
        drain("t3_drain");

        // Granted tvalid high with ready low for 300 cycles: no timeout, grant held.
        m_tready_i = 1'b0;
        burst(0, 8'h50, 1'b1, 1'b1);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk_i);
            if (busy_o) break;
        end
        hold_bad = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk_i);
            if (timeout_o !== 1'b0 || grant_o !== 3'b001 || m_tvalid_o !== 1'b1) hold_bad++;
        end
        check("t4_hold", 32'(hold_bad), 32'd0);
        m_tready_i = 1'b1;
        drain("t4_drain");

        // Reset after the second beat of a port 1 burst.
        burst(1, 8'h60, 1'b1, 1'b0);
        burst(0, 8'h70, 1'b1, 1'b0);
        exp_push(1, 8'h60);
        exp_push(1, 8'h61);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk_i);
            #1;
            if (sb_q.size() == 0) break;
        end
        @(posedge clk_i);
        #2;
        check("t5_busy_before", {31'd0, busy_o}, 32'd1);
        arstn_i = 1'b0;
        #1;
        check("t5_rst_out", {15'd0, m_tvalid_o, busy_o, timeout_o, grant_o, s_tready_o, m_tdata_o}, 32'd0);
        src_push(1, 8'h63);
        src_push(1, 8'h64);
        burst(0, 8'h70, 1'b0, 1'b1);
        burst(1, 8'h62, 1'b0, 1'b1);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        arstn_i = 1'b1;
        @(posedge clk_i);
        #2;
        check("t5_first_grant", {29'd0, grant_o}, 32'd1);
        drain("t5_drain");

        // Three ports continuously valid from reset: bursts 0,1,2,0,1,2.
        @(negedge clk_i);
        arstn_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            burst(0, 8'h80 + W'(3 * k), 1'b1, 1'b1);
            burst(1, 8'h90 + W'(3 * k), 1'b1, 1'b1);
            burst(2, 8'hA0 + W'(3 * k), 1'b1, 1'b1);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        arstn_i = 1'b1;
        drain("t6_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
